// File: rtl/tile_req_gen_if.sv
// Burst-request and read-beat bus between tile_req_gen and the AXI master front-end.
// The master modport belongs to the request generator, the slave modport to the front-end.
interface tile_req_gen_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_W     = 32
);
  logic                  req_valid;
  logic [ADDR_W-1:0]     req_base;
  logic [2:0]            req_sel;
  logic                  req_issend;
  logic [5:0]            req_burst_num;
  logic [2:0]            req_burst_size;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  finish;

  modport master (
    output req_valid, req_base, req_sel, req_issend, req_burst_num, req_burst_size,
    input  arready, rvalid, rdata, finish
  );

  modport slave (
    input  req_valid, req_base, req_sel, req_issend, req_burst_num, req_burst_size,
    output arready, rvalid, rdata, finish
  );
endinterface

// File: rtl/tile_req_gen.sv
// Burst-request sequencer for one tensor-core tile: reads C, A, B, waits for write-back,
// then writes D, tagging every returning read beat with its matrix and beat index.
module tile_req_gen #(
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BURST  = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            cfg_shape,
  input  logic [1:0]            cfg_type,
  input  logic [4*ADDR_W-1:0]   cfg_base,
  input  logic                  wb_go,
  tile_req_gen_if.master        bus,
  output logic                  out_valid,
  output logic [1:0]            out_mat,
  output logic [7:0]            out_beat,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BB = DATA_WIDTH / 8;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(MAX_BURST * BB);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_C   = 3'd1;
  localparam logic [2:0] S_REQ_A   = 3'd2;
  localparam logic [2:0] S_REQ_B   = 3'd3;
  localparam logic [2:0] S_WAIT_WB = 3'd4;
  localparam logic [2:0] S_REQ_D   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // out_mat encoding (mat_t)
  localparam logic [1:0] MAT_A = 2'd0;
  localparam logic [1:0] MAT_B = 2'd1;
  localparam logic [1:0] MAT_C = 2'd2;

  logic [2:0]          state;
  logic [1:0]          shape_q;
  logic [1:0]          type_q;
  logic [4*ADDR_W-1:0] base_q;
  logic                req_valid_q;
  logic [ADDR_W-1:0]   req_addr;
  logic [8:0]          remain;
  logic [5:0]          beat_cnt;
  logic [7:0]          mat_beat;
  logic                waiting;
  logic                wb_seen;

  int         a_elems;
  int         b_elems;
  int         halves;
  logic [8:0] a_beats;
  logic [8:0] b_beats;
  logic [8:0] cd_beats;
  logic [5:0] burst_num;
  logic [1:0] cur_mat;

  function automatic logic [8:0] beats_of(input int bytes);
    int n;
    n = (bytes + BB - 1) / BB;
    if (n < 1) n = 1;
    return n[8:0];
  endfunction

  // Element sizes are tracked in half-bytes so INT4 stays integral.
  always_comb begin
    a_elems = 512;
    b_elems = 128;
    halves  = 1;
    case (shape_q)
      2'd1:    begin a_elems = 256; b_elems = 256; end
      2'd2:    begin a_elems = 128; b_elems = 512; end
      default: ;
    endcase
    case (type_q)
      2'd0:    halves = 8;
      2'd1:    halves = 4;
      2'd2:    halves = 2;
      default: halves = 1;
    endcase
    a_beats   = beats_of(a_elems * halves / 2);
    b_beats   = beats_of(b_elems * halves / 2);
    cd_beats  = beats_of(1024);
    burst_num = (remain >= 9'(MAX_BURST)) ? 6'(MAX_BURST) : remain[5:0];
    case (state)
      S_REQ_A: cur_mat = MAT_A;
      S_REQ_B: cur_mat = MAT_B;
      default: cur_mat = MAT_C;
    endcase
  end

  always_comb begin
    bus.req_valid      = req_valid_q;
    bus.req_base       = req_addr;
    bus.req_issend     = (state == S_REQ_D);
    bus.req_burst_num  = req_valid_q ? burst_num : 6'd0;
    bus.req_burst_size = 3'($clog2(DATA_WIDTH / 8));
    case (state)
      S_REQ_A: bus.req_sel = 3'b100;
      S_REQ_B: bus.req_sel = 3'b010;
      S_REQ_C: bus.req_sel = 3'b001;
      default: bus.req_sel = 3'b000;
    endcase
    busy = (state != S_IDLE);
  end

  // One request is in flight at a time: present it, wait for arready, then drain its beats or finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shape_q     <= 2'd0;
      type_q      <= 2'd0;
      base_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr    <= '0;
      remain      <= 9'd0;
      beat_cnt    <= 6'd0;
      mat_beat    <= 8'd0;
      waiting     <= 1'b0;
      wb_seen     <= 1'b0;
      out_valid   <= 1'b0;
      out_mat     <= 2'd0;
      out_beat    <= 8'd0;
      out_data    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (wb_go && (state == S_REQ_C || state == S_REQ_A || state == S_REQ_B))
        wb_seen <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_shape == 2'b11) begin
              err <= 1'b1;
            end else begin
              shape_q     <= cfg_shape;
              type_q      <= cfg_type;
              base_q      <= cfg_base;
              state       <= S_REQ_C;
              req_addr    <= cfg_base[2*ADDR_W-1 -: ADDR_W];
              remain      <= cd_beats;
              mat_beat    <= 8'd0;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_REQ_C, S_REQ_A, S_REQ_B: begin
          if (req_valid_q) begin
            if (bus.arready) begin
              req_valid_q <= 1'b0;
              waiting     <= 1'b1;
              beat_cnt    <= 6'd0;
            end
          end else if (waiting && bus.rvalid) begin
            out_valid <= 1'b1;
            out_mat   <= cur_mat;
            out_beat  <= mat_beat;
            out_data  <= bus.rdata;
            mat_beat  <= mat_beat + 8'd1;
            beat_cnt  <= beat_cnt + 6'd1;
            if (beat_cnt + 6'd1 == burst_num) begin
              waiting <= 1'b0;
              if (remain != 9'(burst_num)) begin
                remain      <= remain - 9'(burst_num);
                req_addr    <= req_addr + STEP;
                req_valid_q <= 1'b1;
              end else begin
                mat_beat <= 8'd0;
                case (state)
                  S_REQ_C: begin
                    state       <= S_REQ_A;
                    req_addr    <= base_q[4*ADDR_W-1 -: ADDR_W];
                    remain      <= a_beats;
                    req_valid_q <= 1'b1;
                  end
                  S_REQ_A: begin
                    state       <= S_REQ_B;
                    req_addr    <= base_q[3*ADDR_W-1 -: ADDR_W];
                    remain      <= b_beats;
                    req_valid_q <= 1'b1;
                  end
                  default: state <= S_WAIT_WB;
                endcase
              end
            end
          end
        end
        S_WAIT_WB: begin
          if (wb_seen || wb_go) begin
            state       <= S_REQ_D;
            req_addr    <= base_q[ADDR_W-1:0];
            remain      <= cd_beats;
            req_valid_q <= 1'b1;
          end
        end
        S_REQ_D: begin
          if (req_valid_q) begin
            if (bus.arready) begin
              req_valid_q <= 1'b0;
              waiting     <= 1'b1;
            end
          end else if (waiting && bus.finish) begin
            waiting <= 1'b0;
            if (remain != 9'(burst_num)) begin
              remain      <= remain - 9'(burst_num);
              req_addr    <= req_addr + STEP;
              req_valid_q <= 1'b1;
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              wb_seen <= 1'b0;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_req_gen.sv
// Directed bench for tile_req_gen: drives the front-end side of the bus at negedges and
// checks each burst request and tagged read beat against hand-computed expectations.
module tb_tile_req_gen;

  localparam int DW = 256;
  localparam int AW = 32;
  localparam logic [1:0] MAT_A = 2'd0;
  localparam logic [1:0] MAT_B = 2'd1;
  localparam logic [1:0] MAT_C = 2'd2;
  localparam logic [1:0] MAT_D = 2'd3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    cfg_shape;
  logic [1:0]    cfg_type;
  logic [4*AW-1:0] cfg_base;
  logic          wb_go;
  logic          out_valid;
  logic [1:0]    out_mat;
  logic [7:0]    out_beat;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  tile_req_gen_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  tile_req_gen #(.DATA_WIDTH(DW), .MAX_BURST(16), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_shape (cfg_shape),
    .cfg_type  (cfg_type),
    .cfg_base  (cfg_base),
    .wb_go     (wb_go),
    .bus       (bus),
    .out_valid (out_valid),
    .out_mat   (out_mat),
    .out_beat  (out_beat),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic [1:0] shape, input logic [1:0] dtype,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
    cfg_shape = shape;
    cfg_type  = dtype;
    cfg_base  = {a, b, c, d};
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (!bus.req_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_valid) checkOutput("req_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [DW-1:0] pattern(input logic [1:0] mat, input int beat);
    logic [31:0] w;
    w = {6'd0, mat, 8'hA5, 16'(beat)};
    return {8{w}};
  endfunction

  // Walk every burst of one matrix: request fields, acceptance, then beats or a finish pulse.
  task automatic do_matrix(input logic [2:0] sel, input logic [31:0] base, input int total,
                           input logic [1:0] mat, input int first_lat, input int hold,
                           input bit pulse_wb);
    int remaining;
    int k;
    int beat;
    int num;
    int waited;
    logic [DW-1:0] exp_data;
    remaining = total;
    k = 0;
    beat = 0;
    while (remaining > 0) begin
      num = (remaining > 16) ? 16 : remaining;
      wait_req(waited);
      if (!bus.req_valid) return;
      checkOutput("req_latency", 64'(waited), (k == 0) ? 64'(first_lat) : 64'd0);
      checkOutput("req_base", 64'(bus.req_base), 64'(base + 32'(k * 512)));
      checkOutput("req_sel", 64'(bus.req_sel), 64'(sel));
      checkOutput("req_issend", 64'(bus.req_issend), (sel == 3'b000) ? 64'd1 : 64'd0);
      checkOutput("req_burst_num", 64'(bus.req_burst_num), 64'(num));
      if (k == 0 && pulse_wb) wb_go = 1'b1;
      if (k == 0 && hold > 0) begin
        cfg_shape = 2'b11;
        for (int h = 0; h < hold; h++) begin
          start = (h == 0);
          @(negedge clk);
          start = 1'b0;
          wb_go = 1'b0;
          checkOutput("hold_valid", 64'(bus.req_valid), 64'd1);
          checkOutput("hold_base", 64'(bus.req_base), 64'(base));
          checkOutput("hold_num", 64'(bus.req_burst_num), 64'(num));
          checkOutput("hold_sel", 64'(bus.req_sel), 64'(sel));
          checkOutput("busy_start_err", 64'(err), 64'd0);
        end
        bus.arready = 1'b1;
      end
      @(negedge clk);
      wb_go = 1'b0;
      checkOutput("accept_drop", 64'(bus.req_valid), 64'd0);
      if (sel != 3'b000) begin
        for (int b = 0; b < num; b++) begin
          exp_data   = pattern(mat, beat + b);
          bus.rvalid = 1'b1;
          bus.rdata  = exp_data;
          @(negedge clk);
          checkOutput("out_valid", 64'(out_valid), 64'd1);
          checkOutput("out_mat", 64'(out_mat), 64'(mat));
          checkOutput("out_beat", 64'(out_beat), 64'(beat + b));
          checkOutput("out_data", out_data[63:0], exp_data[63:0]);
        end
        bus.rvalid = 1'b0;
      end else begin
        repeat (2) @(negedge clk);
        bus.finish = 1'b1;
        @(negedge clk);
        bus.finish = 1'b0;
      end
      beat      += num;
      remaining -= num;
      k++;
    end
  endtask

  task automatic check_done();
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("done_clear", 64'(done), 64'd0);
    checkOutput("busy_fall", 64'(busy), 64'd0);
  endtask

  // FP32 / M32K16N8 tile: C 32 beats, A 64 beats, B 16 beats, D 32 beats; wb_go arrives in REQ_A.
  task automatic run_fp32(input int hold);
    if (hold > 0) bus.arready = 1'b0;
    applyStimulus(2'd0, 2'd0, 32'h0, 32'h800, 32'hA00, 32'hE00);
    do_matrix(3'b001, 32'hA00, 32, MAT_C, 0, hold, 1'b0);
    do_matrix(3'b100, 32'h000, 64, MAT_A, 0, 0, 1'b1);
    do_matrix(3'b010, 32'h800, 16, MAT_B, 0, 0, 1'b0);
    do_matrix(3'b000, 32'hE00, 32, MAT_D, 1, 0, 1'b0);
    check_done();
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_shape = 2'd0;
    cfg_type = 2'd0;
    cfg_base = '0;
    wb_go = 1'b0;
    bus.arready = 1'b1;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    bus.finish = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_valid", 64'(bus.req_valid), 64'd0);
    checkOutput("rst_req_base", 64'(bus.req_base), 64'd0);
    checkOutput("rst_req_sel", 64'(bus.req_sel), 64'd0);
    checkOutput("rst_burst_num", 64'(bus.req_burst_num), 64'd0);
    checkOutput("rst_burst_size", 64'(bus.req_burst_size), 64'd5);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_done_err", 64'({done, err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] invalid shape and stray rvalid");
    applyStimulus(2'b11, 2'd0, 32'h0, 32'h800, 32'hA00, 32'hE00);
    checkOutput("err_pulse", 64'(err), 64'd1);
    checkOutput("err_busy", 64'(busy), 64'd0);
    checkOutput("err_no_req", 64'(bus.req_valid), 64'd0);
    bus.rvalid = 1'b1;
    @(negedge clk);
    bus.rvalid = 1'b0;
    checkOutput("err_clear", 64'(err), 64'd0);
    checkOutput("stray_no_req", 64'(bus.req_valid), 64'd0);
    @(negedge clk);
    checkOutput("idle_rvalid", 64'(out_valid), 64'd0);

    $display("[TB] FP32 tile with arready held low");
    run_fp32(5);

    $display("[TB] INT4 M8K16N32 tile without early wb_go");
    applyStimulus(2'd2, 2'd3, 32'h1000, 32'h2000, 32'h3000, 32'h4000);
    do_matrix(3'b001, 32'h3000, 32, MAT_C, 0, 0, 1'b0);
    do_matrix(3'b100, 32'h1000, 2, MAT_A, 0, 0, 1'b0);
    do_matrix(3'b010, 32'h2000, 8, MAT_B, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.rvalid = (i == 0);
      @(negedge clk);
      bus.rvalid = 1'b0;
      checkOutput("wait_wb_no_req", 64'(bus.req_valid), 64'd0);
      checkOutput("wait_wb_busy", 64'(busy), 64'd1);
      checkOutput("extra_beat", 64'(out_valid), 64'd0);
    end
    wb_go = 1'b1;
    @(negedge clk);
    wb_go = 1'b0;
    do_matrix(3'b000, 32'h4000, 32, MAT_D, 0, 0, 1'b0);
    check_done();

    $display("[TB] reset during REQ_A");
    applyStimulus(2'd0, 2'd0, 32'h0, 32'h800, 32'hA00, 32'hE00);
    do_matrix(3'b001, 32'hA00, 32, MAT_C, 0, 0, 1'b0);
    wait_req(waited);
    checkOutput("pre_rst_sel", 64'(bus.req_sel), 64'b100);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.req_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_sel", 64'(bus.req_sel), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_req", 64'(bus.req_valid), 64'd0);
    end
    run_fp32(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
